semis_cmp_array: RTL and testbench

- NCH-channel clocked digital comparator array. Each channel compares two WIDTH-bit unsigned operands with programmable hysteresis and a consecutive-sample debounce filter.
- Each channel drives an output bit gated by an enable, mirroring a tristate comparator output.
- Sits between the pad/ADC sample interface and the top-level uo_out mapping; one channel replaces the earlier single-bit inverter/tristate comparator.

---
 rtl/semis_cmp_pkg.sv | 16 +
 rtl/semis_cmp_chan.sv | 109 ++++++++++
 rtl/semis_cmp_array.sv | 69 ++++++
 tb/tb_semis_cmp_array.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/semis_cmp_pkg.sv
// semis_cmp_pkg: shared definitions for the comparator array.
//   MODE_CONT / MODE_ONESHOT : encodings of the mode input.
//   cnt_width()              : width of a debounce counter that can hold 0..filt.
package semis_cmp_pkg;

  localparam logic MODE_CONT    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  // Counter only ever reaches filt-1, but sizing for filt keeps filt=1 at one bit.
  function automatic int unsigned cnt_width(input int unsigned filt);
    int unsigned w;
    w = $clog2(filt + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/semis_cmp_chan.sv
// semis_cmp_chan: one comparator channel with hysteresis, debounce filter,
// one-shot hold and state-change pulse.
// Ports:
//   clk_i          clock
//   rst_i          synchronous active-high reset
//   sample_valid_i operands are sampled this cycle
//   a_i, b_i       unsigned operands
//   hyst_i         unsigned hysteresis
//   mode_i         MODE_CONT or MODE_ONESHOT
//   clr_i          clears state, filter count and hold (wins over a sample)
//   state_o        filtered comparison state
//   trip_o         one-cycle pulse after the state changed
module semis_cmp_chan
  import semis_cmp_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned HYST_W = 4,
  parameter int unsigned FILT   = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sample_valid_i,
  input  logic [WIDTH-1:0]  a_i,
  input  logic [WIDTH-1:0]  b_i,
  input  logic [HYST_W-1:0] hyst_i,
  input  logic              mode_i,
  input  logic              clr_i,
  output logic              state_o,
  output logic              trip_o
);

  // One spare bit over the widest sum, so a + hyst never wraps.
  localparam int unsigned ExtW = WIDTH + HYST_W + 1;
  localparam int unsigned CntW = cnt_width(FILT);
  localparam logic [CntW-1:0] CntLast = CntW'(FILT - 1);

  logic            s_q, s_d;
  logic            hold_q, hold_d;
  logic            trip_q, trip_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [ExtW-1:0] a_ext, b_ext, h_ext;
  logic            raw;
  logic            hold_active;

  always_comb begin
    a_ext = ExtW'(a_i);
    b_ext = ExtW'(b_i);
    h_ext = ExtW'(hyst_i);
    if (!s_q) begin
      raw = (a_ext > (b_ext + h_ext));
    end else begin
      raw = !((a_ext + h_ext) < b_ext);
    end
  end

  // A hold left over from one-shot mode is ignored once mode returns to continuous.
  assign hold_active = hold_q && (mode_i == MODE_ONESHOT);

  always_comb begin
    s_d    = s_q;
    cnt_d  = cnt_q;
    hold_d = hold_q;
    if (clr_i) begin
      s_d    = 1'b0;
      cnt_d  = '0;
      hold_d = 1'b0;
    end else begin
      if (mode_i == MODE_CONT) begin
        hold_d = 1'b0;
      end
      if (sample_valid_i && !hold_active) begin
        if (raw != s_q) begin
          // cnt_q counts earlier disagreeing samples; this one completes the run.
          if (cnt_q == CntLast) begin
            s_d   = raw;
            cnt_d = '0;
            if (raw && (mode_i == MODE_ONESHOT)) begin
              hold_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
    end
    trip_d = (s_d != s_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s_q    <= 1'b0;
      cnt_q  <= '0;
      hold_q <= 1'b0;
      trip_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      cnt_q  <= cnt_d;
      hold_q <= hold_d;
      trip_q <= trip_d;
    end
  end

  assign state_o = s_q;
  assign trip_o  = trip_q;

endmodule

// File: rtl/semis_cmp_array.sv
// semis_cmp_array: NCH-channel clocked comparator array.
// Ports:
//   clk_i          clock
//   rst_i          synchronous active-high reset
//   sample_valid_i operands sampled this cycle (all channels)
//   op_a_i, op_b_i channel i operands at [i*WIDTH +: WIDTH]
//   hyst_i         hysteresis shared by all channels
//   en_i           per-channel output enable
//   mode_i         0 = continuous, 1 = one-shot (trip and hold)
//   clr_i          per-channel clear of filter, state and hold
//   cmp_out_o      filtered state gated by the registered enable
//   cmp_oe_o       registered enable
//   trip_o         one-cycle pulse per channel on state change (not gated)
module semis_cmp_array
  import semis_cmp_pkg::*;
#(
  parameter int unsigned NCH    = 4,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned FILT   = 3,
  parameter int unsigned HYST_W = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 sample_valid_i,
  input  logic [NCH*WIDTH-1:0] op_a_i,
  input  logic [NCH*WIDTH-1:0] op_b_i,
  input  logic [HYST_W-1:0]    hyst_i,
  input  logic [NCH-1:0]       en_i,
  input  logic                 mode_i,
  input  logic [NCH-1:0]       clr_i,
  output logic [NCH-1:0]       cmp_out_o,
  output logic [NCH-1:0]       cmp_oe_o,
  output logic [NCH-1:0]       trip_o
);

  logic [NCH-1:0] en_q;
  logic [NCH-1:0] state;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_q <= '0;
    end else begin
      en_q <= en_i;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    semis_cmp_chan #(
      .WIDTH  (WIDTH),
      .HYST_W (HYST_W),
      .FILT   (FILT)
    ) u_chan (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .sample_valid_i (sample_valid_i),
      .a_i            (op_a_i[i*WIDTH +: WIDTH]),
      .b_i            (op_b_i[i*WIDTH +: WIDTH]),
      .hyst_i         (hyst_i),
      .mode_i         (mode_i),
      .clr_i          (clr_i[i]),
      .state_o        (state[i]),
      .trip_o         (trip_o[i])
    );
  end

  assign cmp_oe_o  = en_q;
  assign cmp_out_o = state & en_q;

endmodule

// File: tb/tb_semis_cmp_array.sv
module tb_semis_cmp_array;

  localparam int unsigned NCH = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned FILT = 3;
  localparam int unsigned HYST_W = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 sample_valid;
  logic [NCH*WIDTH-1:0] op_a, op_b;
  logic [HYST_W-1:0]    hyst;
  logic [NCH-1:0]       en;
  logic                 mode;
  logic [NCH-1:0]       clr;
  logic [NCH-1:0]       cmp_out, cmp_oe, trip;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  semis_cmp_array #(
    .NCH    (NCH),
    .WIDTH  (WIDTH),
    .FILT   (FILT),
    .HYST_W (HYST_W)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .sample_valid_i (sample_valid),
    .op_a_i         (op_a),
    .op_b_i         (op_b),
    .hyst_i         (hyst),
    .en_i           (en),
    .mode_i         (mode),
    .clr_i          (clr),
    .cmp_out_o      (cmp_out),
    .cmp_oe_o       (cmp_oe),
    .trip_o         (trip)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int ch, input logic [7:0] a, input logic [7:0] b);
    op_a[ch*WIDTH +: WIDTH] = a;
    op_b[ch*WIDTH +: WIDTH] = b;
  endtask

  task automatic samp(input int ch, input logic [7:0] a, input logic [7:0] b, input int n);
    set_ops(ch, a, b);
    for (int k = 0; k < n; k++) begin
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
    end
  endtask

  task automatic clr_pulse(input int ch);
    clr[ch] = 1'b1;
    tick();
    clr = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 4'hF;
    tick();
    tick();
    total_cnt++; if (cmp_out !== 4'h0) $display("FAIL reset_cmp_out got %b want 0000", cmp_out); else pass_cnt++;
    total_cnt++; if (cmp_oe !== 4'h0) $display("FAIL reset_cmp_oe got %b want 0000", cmp_oe); else pass_cnt++;
    total_cnt++; if (trip !== 4'h0) $display("FAIL reset_trip got %b want 0000", trip); else pass_cnt++;
    rst = 1'b0;
    tick();
    total_cnt++; if (cmp_oe !== 4'hF) $display("FAIL release_cmp_oe got %b want 1111", cmp_oe); else pass_cnt++;
    total_cnt++; if (cmp_out !== 4'h0) $display("FAIL release_cmp_out got %b want 0000", cmp_out); else pass_cnt++;
  endtask

  task automatic test_basic();
    hyst = '0;
    samp(0, 8'd10, 8'd5, 1);
    total_cnt++; if (cmp_out[0] !== 1'b0) $display("FAIL basic_v1 got %b want 0", cmp_out[0]); else pass_cnt++;
    total_cnt++; if (trip !== 4'h0) $display("FAIL basic_v1_trip got %b want 0000", trip); else pass_cnt++;
    samp(0, 8'd10, 8'd5, 1);
    total_cnt++; if (cmp_out[0] !== 1'b0) $display("FAIL basic_v2 got %b want 0", cmp_out[0]); else pass_cnt++;
    samp(0, 8'd10, 8'd5, 1);
    total_cnt++; if (cmp_out !== 4'b0001) $display("FAIL basic_v3 got %b want 0001", cmp_out); else pass_cnt++;
    total_cnt++; if (trip !== 4'b0001) $display("FAIL basic_v3_trip got %b want 0001", trip); else pass_cnt++;
    tick();
    total_cnt++; if (trip !== 4'b0000) $display("FAIL basic_trip_once got %b want 0000", trip); else pass_cnt++;
    total_cnt++; if (cmp_out !== 4'b0001) $display("FAIL basic_hold got %b want 0001", cmp_out); else pass_cnt++;
    op_a = '0;
    op_b = '0;
  endtask

  task automatic test_hyst();
    clr_pulse(0);
    total_cnt++; if (cmp_out[0] !== 1'b0) $display("FAIL hyst_clr got %b want 0", cmp_out[0]); else pass_cnt++;
    total_cnt++; if (trip !== 4'b0001) $display("FAIL hyst_clr_trip got %b want 0001", trip); else pass_cnt++;
    hyst = 4'd4;
    samp(0, 8'd12, 8'd8, 3);
    total_cnt++; if (cmp_out[0] !== 1'b0) $display("FAIL hyst_12_8 got %b want 0", cmp_out[0]); else pass_cnt++;
    samp(0, 8'd13, 8'd8, 3);
    total_cnt++; if (cmp_out[0] !== 1'b1) $display("FAIL hyst_13_8 got %b want 1", cmp_out[0]); else pass_cnt++;
    samp(0, 8'd5, 8'd8, 3);
    total_cnt++; if (cmp_out[0] !== 1'b1) $display("FAIL hyst_5_8 got %b want 1", cmp_out[0]); else pass_cnt++;
    total_cnt++; if (trip !== 4'b0000) $display("FAIL hyst_5_8_trip got %b want 0000", trip); else pass_cnt++;
    samp(0, 8'd3, 8'd8, 2);
    total_cnt++; if (cmp_out[0] !== 1'b1) $display("FAIL hyst_3_8_x2 got %b want 1", cmp_out[0]); else pass_cnt++;
    samp(0, 8'd3, 8'd8, 1);
    total_cnt++; if (cmp_out[0] !== 1'b0) $display("FAIL hyst_3_8_x3 got %b want 0", cmp_out[0]); else pass_cnt++;
    total_cnt++; if (trip !== 4'b0001) $display("FAIL hyst_clear_trip got %b want 0001", trip); else pass_cnt++;
    hyst = '0;
    op_a = '0;
    op_b = '0;
  endtask

  task automatic test_filter_interrupt();
    samp(0, 8'd10, 8'd5, 2);
    samp(0, 8'd5, 8'd10, 1);
    samp(0, 8'd10, 8'd5, 2);
    total_cnt++; if (cmp_out[0] !== 1'b0) $display("FAIL filt_interrupted got %b want 0", cmp_out[0]); else pass_cnt++;
    samp(0, 8'd10, 8'd5, 1);
    total_cnt++; if (cmp_out[0] !== 1'b1) $display("FAIL filt_third got %b want 1", cmp_out[0]); else pass_cnt++;
    op_a = '0;
    op_b = '0;
    clr_pulse(0);
  endtask

  task automatic test_oneshot();
    mode = 1'b1;
    samp(0, 8'd10, 8'd5, 3);
    total_cnt++; if (cmp_out[0] !== 1'b1) $display("FAIL os_trip got %b want 1", cmp_out[0]); else pass_cnt++;
    total_cnt++; if (trip !== 4'b0001) $display("FAIL os_trip_pulse got %b want 0001", trip); else pass_cnt++;
    samp(0, 8'd0, 8'd255, 5);
    total_cnt++; if (cmp_out[0] !== 1'b1) $display("FAIL os_hold got %b want 1", cmp_out[0]); else pass_cnt++;
    total_cnt++; if (trip !== 4'b0000) $display("FAIL os_hold_trip got %b want 0000", trip); else pass_cnt++;
    clr_pulse(0);
    total_cnt++; if (cmp_out[0] !== 1'b0) $display("FAIL os_clr got %b want 0", cmp_out[0]); else pass_cnt++;
    total_cnt++; if (trip !== 4'b0001) $display("FAIL os_clr_trip got %b want 0001", trip); else pass_cnt++;
    // Two disagreeing samples, then clr alongside a third: clr must win and restart the count.
    samp(0, 8'd10, 8'd5, 2);
    clr[0] = 1'b1;
    sample_valid = 1'b1;
    tick();
    clr = '0;
    sample_valid = 1'b0;
    total_cnt++; if (cmp_out[0] !== 1'b0) $display("FAIL os_clr_wins got %b want 0", cmp_out[0]); else pass_cnt++;
    total_cnt++; if (trip !== 4'b0000) $display("FAIL os_clr_wins_trip got %b want 0000", trip); else pass_cnt++;
    samp(0, 8'd10, 8'd5, 2);
    total_cnt++; if (cmp_out[0] !== 1'b0) $display("FAIL os_cnt_restart got %b want 0", cmp_out[0]); else pass_cnt++;
    samp(0, 8'd10, 8'd5, 1);
    total_cnt++; if (cmp_out[0] !== 1'b1) $display("FAIL os_retrip got %b want 1", cmp_out[0]); else pass_cnt++;
    mode = 1'b0;
    tick();
    total_cnt++; if (cmp_out[0] !== 1'b1) $display("FAIL os_mode_switch_keep got %b want 1", cmp_out[0]); else pass_cnt++;
    samp(0, 8'd0, 8'd255, 3);
    total_cnt++; if (cmp_out[0] !== 1'b0) $display("FAIL os_hold_released got %b want 0", cmp_out[0]); else pass_cnt++;
    op_a = '0;
    op_b = '0;
  endtask

  task automatic test_enable();
    samp(1, 8'd200, 8'd100, 3);
    total_cnt++; if (cmp_out !== 4'b0010) $display("FAIL en_set got %b want 0010", cmp_out); else pass_cnt++;
    en = 4'b1101;
    tick();
    total_cnt++; if (cmp_out !== 4'b0000) $display("FAIL en_gate_out got %b want 0000", cmp_out); else pass_cnt++;
    total_cnt++; if (cmp_oe !== 4'b1101) $display("FAIL en_gate_oe got %b want 1101", cmp_oe); else pass_cnt++;
    samp(1, 8'd0, 8'd50, 3);
    total_cnt++; if (trip !== 4'b0010) $display("FAIL en_trip_ungated got %b want 0010", trip); else pass_cnt++;
    en = 4'hF;
    tick();
    total_cnt++; if (cmp_oe !== 4'hF) $display("FAIL en_restore got %b want 1111", cmp_oe); else pass_cnt++;
    op_a = '0;
    op_b = '0;
  endtask

  task automatic test_overflow();
    hyst = 4'd15;
    // 250+15 = 265 would wrap to 9 in 8 bits and wrongly set.
    samp(2, 8'd255, 8'd250, 3);
    total_cnt++; if (cmp_out[2] !== 1'b0) $display("FAIL ovf_no_wrap got %b want 0", cmp_out[2]); else pass_cnt++;
    samp(2, 8'd255, 8'd0, 3);
    total_cnt++; if (cmp_out !== 4'b0100) $display("FAIL ovf_set got %b want 0100", cmp_out); else pass_cnt++;
    samp(2, 8'd255, 8'd255, 3);
    total_cnt++; if (cmp_out[2] !== 1'b1) $display("FAIL ovf_hold got %b want 1", cmp_out[2]); else pass_cnt++;
    hyst = '0;
    op_a = '0;
    op_b = '0;
  endtask

  task automatic test_rst_mid();
    samp(0, 8'd10, 8'd5, 2);
    rst = 1'b1;
    sample_valid = 1'b1;
    tick();
    rst = 1'b0;
    sample_valid = 1'b0;
    total_cnt++; if (cmp_out !== 4'h0) $display("FAIL rstmid_out got %b want 0000", cmp_out); else pass_cnt++;
    total_cnt++; if (cmp_oe !== 4'h0) $display("FAIL rstmid_oe got %b want 0000", cmp_oe); else pass_cnt++;
    total_cnt++; if (trip !== 4'h0) $display("FAIL rstmid_trip got %b want 0000", trip); else pass_cnt++;
    tick();
    samp(0, 8'd10, 8'd5, 2);
    total_cnt++; if (cmp_out !== 4'h0) $display("FAIL rstmid_restart got %b want 0000", cmp_out); else pass_cnt++;
    samp(0, 8'd10, 8'd5, 1);
    total_cnt++; if (cmp_out !== 4'b0001) $display("FAIL rstmid_flip got %b want 0001", cmp_out); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    sample_valid = 1'b0;
    op_a = '0;
    op_b = '0;
    hyst = '0;
    en = '0;
    mode = 1'b0;
    clr = '0;
    test_reset();
    test_basic();
    test_hyst();
    test_filter_interrupt();
    test_oneshot();
    test_enable();
    test_overflow();
    test_rst_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
